// File: rtl/calc_sequencer_pkg.sv
// calc_pkg: shared types and key-decoding helpers for the calculator
// sequencer.
//   key_e       - 4x4 keypad index, all 16 codes
//   alu_op_e    - ALU operation select
//   seq_state_e - sequencer FSM states
//   is_digit / digit_val / is_op / key_op - key classification helpers
package calc_pkg;

  typedef enum logic [3:0] {
    K_1   = 4'd0,  K_2   = 4'd1,  K_3   = 4'd2,  K_ADD = 4'd3,
    K_4   = 4'd4,  K_5   = 4'd5,  K_6   = 4'd6,  K_SUB = 4'd7,
    K_7   = 4'd8,  K_8   = 4'd9,  K_9   = 4'd10, K_MUL = 4'd11,
    K_EQ  = 4'd12, K_0   = 4'd13, K_CLR = 4'd14, K_NEG = 4'd15
  } key_e;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2
  } alu_op_e;

  typedef enum logic [2:0] {
    ENTER_A,
    ENTER_B,
    ISSUE,
    WAIT_ALU,
    DONE
  } seq_state_e;

  function automatic logic is_digit(input logic [3:0] k);
    case (k)
      K_0, K_1, K_2, K_3, K_4, K_5, K_6, K_7, K_8, K_9: return 1'b1;
      default:                                           return 1'b0;
    endcase
  endfunction

  // Keypad index to decimal value; non-digit keys map to 0.
  function automatic logic [3:0] digit_val(input logic [3:0] k);
    case (k)
      K_1:     return 4'd1;
      K_2:     return 4'd2;
      K_3:     return 4'd3;
      K_4:     return 4'd4;
      K_5:     return 4'd5;
      K_6:     return 4'd6;
      K_7:     return 4'd7;
      K_8:     return 4'd8;
      K_9:     return 4'd9;
      default: return 4'd0;
    endcase
  endfunction

  function automatic logic is_op(input logic [3:0] k);
    return (k == K_ADD) || (k == K_SUB) || (k == K_MUL);
  endfunction

  function automatic alu_op_e key_op(input logic [3:0] k);
    case (k)
      K_SUB:   return OP_SUB;
      K_MUL:   return OP_MUL;
      default: return OP_ADD;
    endcase
  endfunction

endpackage

// File: rtl/calc_sequencer_if.sv
// calc_sequencer_if: key handshake, ALU start/done bus and display outputs
// of the calculator sequencer.
//   slave  - sequencer side (accepts keys, drives ALU request and display)
//   master - environment side (key decoder + ALU + display consumer)
interface calc_sequencer_if #(
  parameter int W = 16
);
  logic                key_valid;
  logic [3:0]          key_code;
  logic                key_ready;
  logic                alu_start;
  logic [1:0]          alu_op;
  logic signed [W-1:0] alu_a;
  logic signed [W-1:0] alu_b;
  logic                alu_done;
  logic signed [W-1:0] alu_result;
  logic                alu_ovf;
  logic signed [W-1:0] display_output;
  logic                complete;
  logic                error;

  modport slave (
    input  key_valid, key_code, alu_done, alu_result, alu_ovf,
    output key_ready, alu_start, alu_op, alu_a, alu_b,
           display_output, complete, error
  );

  modport master (
    output key_valid, key_code, alu_done, alu_result, alu_ovf,
    input  key_ready, alu_start, alu_op, alu_a, alu_b,
           display_output, complete, error
  );
endinterface

// File: rtl/calc_sequencer_operand_accum.sv
// operand_accum: sign-magnitude decimal digit accumulator for one operand.
//   clk, nRST  - clock, async active-low reset
//   clr        - zero the operand (digit/neg strobes in the same cycle apply
//                on top of the cleared value)
//   digit_stb  - append digit: mag <- mag*10 + digit, dropped if > MAX_MAG
//   neg_stb    - toggle sign
//   load_stb   - load a full signed value (chained result), overrides all
//   value      - signed operand; a negative zero reads as 0
//   entered    - at least one digit key seen since the last clear
module operand_accum #(
  parameter int W       = 16,
  parameter int MAX_MAG = 32767
) (
  input  logic                clk,
  input  logic                nRST,
  input  logic                clr,
  input  logic                digit_stb,
  input  logic [3:0]          digit,
  input  logic                neg_stb,
  input  logic                load_stb,
  input  logic signed [W-1:0] load_val,
  output logic signed [W-1:0] value,
  output logic                entered
);
  // Magnitude is a full W bits so a loaded -2^(W-1) keeps its magnitude.
  logic [W-1:0] mag_q, mag_base;
  logic         neg_q, neg_base, entered_q;
  logic [W+3:0] mag_next;

  always_comb begin
    mag_base = clr ? '0 : mag_q;
    neg_base = clr ? 1'b0 : neg_q;
    mag_next = {4'd0, mag_base} * (W+4)'(10) + (W+4)'(digit);
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      mag_q     <= '0;
      neg_q     <= 1'b0;
      entered_q <= 1'b0;
    end else if (load_stb) begin
      mag_q     <= load_val[W-1] ? $unsigned(-load_val) : $unsigned(load_val);
      neg_q     <= load_val[W-1];
      entered_q <= 1'b1;
    end else begin
      if (digit_stb && (mag_next <= (W+4)'(MAX_MAG))) mag_q <= mag_next[W-1:0];
      else                                            mag_q <= mag_base;
      neg_q     <= neg_base ^ neg_stb;
      entered_q <= (clr ? 1'b0 : entered_q) | digit_stb;
    end
  end

  assign value   = neg_q ? -$signed(mag_q) : $signed(mag_q);
  assign entered = entered_q;
endmodule

// File: rtl/calc_sequencer.sv
// calc_sequencer: builds signed operands A/B from keypad codes, issues one
// start/done transaction to the shared ALU on '=', and shows the result.
//   clk, nRST - clock, async active-low reset
//   bus       - calc_sequencer_if.slave: key valid/ready, ALU start/op/a/b,
//               ALU done/result/ovf, display_output/complete/error
// Build option: CALC_CHAIN_EN - an operator key after a result reuses the
// result as A and continues entry of B; otherwise such a key is dropped.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int W       = 16,
  parameter int MAX_MAG = 32767
) (
  input  logic            clk,
  input  logic            nRST,
  calc_sequencer_if.slave bus
);
  seq_state_e          state_q, state_d;
  alu_op_e             op_q;
  logic                b_touched_q, cmp_q, err_q;
  logic signed [W-1:0] res_q, disp;
  logic                rdy, acc, k_dig, k_op;
  logic [3:0]          k, dval;
  logic                a_clr, b_clr, a_dig, b_dig, a_neg, b_neg, a_load;
  logic                op_ld, res_ld, cmp_clr, err_clr;
  logic signed [W-1:0] a_val, b_val;
  logic                a_entered, b_entered;

  assign k     = bus.key_code;
  assign k_dig = is_digit(k);
  assign k_op  = is_op(k);
  assign dval  = digit_val(k);

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) state_q <= ENTER_A;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    a_clr = 1'b0; b_clr = 1'b0; a_dig = 1'b0; b_dig = 1'b0;
    a_neg = 1'b0; b_neg = 1'b0; a_load = 1'b0;
    op_ld = 1'b0; res_ld = 1'b0; cmp_clr = 1'b0; err_clr = 1'b0;
    rdy   = (state_q == ENTER_A) || (state_q == ENTER_B) || (state_q == DONE);
    acc   = bus.key_valid && rdy;
    if (acc && k == K_CLR) begin
      a_clr = 1'b1; b_clr = 1'b1; cmp_clr = 1'b1; err_clr = 1'b1;
      state_d = ENTER_A;
    end else begin
      case (state_q)
        ENTER_A: if (acc) begin
          if (k_dig)           a_dig = 1'b1;
          else if (k == K_NEG) a_neg = 1'b1;
          else if (k_op) begin
            op_ld   = 1'b1;
            state_d = ENTER_B;
          end
        end
        ENTER_B: if (acc) begin
          if (k_dig)           b_dig = 1'b1;
          else if (k == K_NEG) b_neg = 1'b1;
          // Operator may be corrected only until B has been touched.
          else if (k_op)       op_ld = !b_touched_q;
          else if (k == K_EQ)  state_d = ISSUE;
        end
        ISSUE:    state_d = WAIT_ALU;
        WAIT_ALU: if (bus.alu_done) begin
          res_ld  = 1'b1;
          state_d = DONE;
        end
        DONE: if (acc) begin
          if (k_dig || k == K_NEG) begin
            // First key of a fresh expression.
            a_clr = 1'b1; b_clr = 1'b1; cmp_clr = 1'b1;
            a_dig = k_dig;
            a_neg = (k == K_NEG);
            state_d = ENTER_A;
          end else if (k_op) begin
`ifdef CALC_CHAIN_EN
            a_load  = 1'b1;
            b_clr   = 1'b1;
            op_ld   = 1'b1;
            cmp_clr = 1'b1;
            state_d = ENTER_B;
`endif
          end
        end
        default: state_d = ENTER_A;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      op_q        <= OP_ADD;
      b_touched_q <= 1'b0;
      res_q       <= '0;
      cmp_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      if (op_ld) op_q <= key_op(k);
      if (b_clr)              b_touched_q <= 1'b0;
      else if (b_dig | b_neg) b_touched_q <= 1'b1;
      if (res_ld) begin
        res_q <= bus.alu_result;
        err_q <= bus.alu_ovf;
        cmp_q <= 1'b1;
      end else begin
        if (cmp_clr) cmp_q <= 1'b0;
        if (err_clr) err_q <= 1'b0;
      end
    end
  end

  operand_accum #(.W(W), .MAX_MAG(MAX_MAG)) u_acc_a (
    .clk(clk), .nRST(nRST), .clr(a_clr), .digit_stb(a_dig), .digit(dval),
    .neg_stb(a_neg), .load_stb(a_load), .load_val(res_q),
    .value(a_val), .entered(a_entered)
  );

  operand_accum #(.W(W), .MAX_MAG(MAX_MAG)) u_acc_b (
    .clk(clk), .nRST(nRST), .clr(b_clr), .digit_stb(b_dig), .digit(dval),
    .neg_stb(b_neg), .load_stb(1'b0), .load_val('0),
    .value(b_val), .entered(b_entered)
  );

  // Until B has a digit the display keeps showing A (including a chained A).
  always_comb begin
    case (state_q)
      ENTER_A: disp = a_entered ? a_val : '0;
      DONE:    disp = res_q;
      default: disp = b_entered ? b_val : a_val;
    endcase
  end

  // Operands are frozen while key_ready is low, so alu_a/b/op hold steady
  // from ISSUE until alu_done without extra capture registers.
  assign bus.key_ready      = rdy;
  assign bus.alu_start      = (state_q == ISSUE);
  assign bus.alu_op         = op_q;
  assign bus.alu_a          = a_val;
  assign bus.alu_b          = b_val;
  assign bus.display_output = disp;
  assign bus.complete       = cmp_q;
  assign bus.error          = err_q;
endmodule

// File: tb/tb_calc_sequencer.sv
module tb_calc_sequencer;
  localparam int K1 = 0, K2 = 1, K3 = 2, KADD = 3, K4 = 4, K5 = 5, K6 = 6, KSUB = 7;
  localparam int K7 = 8, K8 = 9, K9 = 10, KMUL = 11, KEQ = 12, K0 = 13, KCLR = 14, KNEG = 15;

  logic clk = 1'b0;
  logic nRST = 1'b0;
  always #5 clk = ~clk;

  calc_sequencer_if #(.W(16)) bus();
  calc_sequencer #(.W(16), .MAX_MAG(32767)) dut (.clk(clk), .nRST(nRST), .bus(bus));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // ---------------- ALU behaviour (shared by responder and model) --------
  function automatic void alu_calc(input int op, input int a, input int b,
                                   output logic signed [15:0] res, output logic ovf);
    int r;
    r   = (op == 1) ? a - b : (op == 2) ? a * b : a + b;
    ovf = (r > 32767) || (r < -32768);
    res = 16'(r);
  endfunction

  int alu_lat = 2;
  int start_pulses = 0;
  logic [1:0] cap_op;
  logic signed [15:0] cap_a, cap_b;

  always @(negedge clk) if (bus.alu_start === 1'b1) start_pulses++;

  initial begin
    logic signed [15:0] r;
    logic o;
    bus.alu_done = 1'b0; bus.alu_result = '0; bus.alu_ovf = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.alu_start === 1'b1) begin
        cap_op = bus.alu_op; cap_a = bus.alu_a; cap_b = bus.alu_b;
        alu_calc(int'(cap_op), int'(cap_a), int'(cap_b), r, o);
        repeat (alu_lat) @(negedge clk);
        bus.alu_done = 1'b1; bus.alu_result = r; bus.alu_ovf = o;
        @(negedge clk);
        bus.alu_done = 1'b0; bus.alu_ovf = 1'b0;
      end
    end
  end

  // ---------------- reference model (spec-level) -------------------------
  int dmap[16] = '{1, 2, 3, -1, 4, 5, 6, -1, 7, 8, 9, -1, -1, 0, -1, -1};
  int m_st = 0;  // 0 entering A, 1 entering B, 2 result shown
  int am = 0, bm = 0, m_op = 0, m_res = 0;
  bit an = 0, bn = 0, bdig = 0, btouch = 0, m_cmp = 0, m_err = 0;

  function automatic int sv(int m, bit n); return n ? -m : m; endfunction
  function automatic int macc(int m, int d); return (m * 10 + d <= 32767) ? m * 10 + d : m; endfunction
  function automatic bit isop(int k); return k == KADD || k == KSUB || k == KMUL; endfunction
  function automatic int opof(int k); return (k == KSUB) ? 1 : (k == KMUL) ? 2 : 0; endfunction

  task automatic m_clear();
    am = 0; an = 0; bm = 0; bn = 0; bdig = 0; btouch = 0;
  endtask

  function automatic int m_display();
    if (m_st == 0) return sv(am, an);
    if (m_st == 1) return bdig ? sv(bm, bn) : sv(am, an);
    return m_res;
  endfunction

  task automatic m_key(input int k, output bit launch);
    int d;
    logic signed [15:0] r;
    logic o;
    launch = 0;
    d = dmap[k];
    if (k == KCLR) begin
      m_clear(); m_cmp = 0; m_err = 0; m_st = 0;
    end else if (m_st == 0) begin
      if (d >= 0) am = macc(am, d);
      else if (k == KNEG) an = !an;
      else if (isop(k)) begin m_op = opof(k); m_st = 1; end
    end else if (m_st == 1) begin
      if (d >= 0) begin bm = macc(bm, d); bdig = 1; btouch = 1; end
      else if (k == KNEG) begin bn = !bn; btouch = 1; end
      else if (isop(k)) begin if (!btouch) m_op = opof(k); end
      else if (k == KEQ) begin
        alu_calc(m_op, sv(am, an), sv(bm, bn), r, o);
        m_res = int'(r); m_err = o; m_cmp = 1; m_st = 2; launch = 1;
      end
    end else begin
      if (d >= 0 || k == KNEG) begin
        m_clear(); m_cmp = 0; m_st = 0;
        if (d >= 0) am = d; else an = 1;
      end else if (isop(k)) begin
`ifdef CALC_CHAIN_EN
        m_clear();
        am = (m_res < 0) ? -m_res : m_res; an = (m_res < 0);
        m_op = opof(k); m_cmp = 0; m_st = 1;
`endif
      end
    end
  endtask

  // ---------------- stimulus helpers (called at a negedge) ---------------
  int last_wait;

  task automatic press(input int k);
    bus.key_valid = 1'b1; bus.key_code = 4'(k); last_wait = 0;
    while (bus.key_ready !== 1'b1 && last_wait < 100) begin
      @(negedge clk); last_wait++;
    end
    if (last_wait >= 100) begin
      checks++; failures++;
      $display("FAIL key_accept_timeout: key %0d not accepted, key_ready=%b", k, bus.key_ready);
      bus.key_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    bus.key_valid = 1'b0;
  endtask

  task automatic wait_complete();
    int n = 0;
    while (bus.complete !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) begin
      checks++; failures++;
      $display("FAIL complete_timeout: complete=%b after %0d cycles", bus.complete, n);
    end
  endtask

  task automatic key(input int k, input bit wait_cmp = 1'b1);
    bit launch;
    press(k);
    m_key(k, launch);
    if (launch && wait_cmp) wait_complete();
  endtask

  // ---------------- vector table -----------------------------------------
  typedef struct {
    int n;
    int keys[8];
    int disp;
    int cmp;
    int err;
  } vec_t;
  vec_t vt[14];

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    bus.key_valid = 1'b0; bus.key_code = '0;

    vt[0]  = '{4, '{K5, KSUB, K4, KEQ, 0, 0, 0, 0}, 1, 1, 0};
    vt[1]  = '{5, '{KNEG, K5, KSUB, K4, KEQ, 0, 0, 0}, -9, 1, 0};
    vt[2]  = '{5, '{K4, K0, K0, K0, K0, 0, 0, 0}, 4000, 0, 0};
    vt[3]  = '{6, '{K4, K0, K0, K0, K0, KNEG, 0, 0}, -4000, 0, 0};
    vt[4]  = '{5, '{K9, KADD, KSUB, K2, KEQ, 0, 0, 0}, 7, 1, 0};
    vt[5]  = '{6, '{K7, KCLR, K2, KMUL, K3, KEQ, 0, 0}, 6, 1, 0};
`ifdef CALC_CHAIN_EN
    vt[6]  = '{7, '{K3, KADD, K4, KEQ, KMUL, K2, KEQ, 0}, 14, 1, 0};
`else
    vt[6]  = '{7, '{K3, KADD, K4, KEQ, KMUL, K2, KEQ, 0}, 2, 0, 0};
`endif
    vt[7]  = '{2, '{K8, KEQ, 0, 0, 0, 0, 0, 0}, 8, 0, 0};
    vt[8]  = '{4, '{K2, KSUB, K5, KEQ, 0, 0, 0, 0}, -3, 1, 0};
    vt[9]  = '{3, '{K1, KNEG, KNEG, 0, 0, 0, 0, 0}, 1, 0, 0};
    vt[10] = '{2, '{KNEG, K0, 0, 0, 0, 0, 0, 0}, 0, 0, 0};
    vt[11] = '{5, '{K6, KMUL, KNEG, K7, KEQ, 0, 0, 0}, -42, 1, 0};
    vt[12] = '{3, '{KMUL, K5, KEQ, 0, 0, 0, 0, 0}, 0, 1, 0};
    vt[13] = '{5, '{K3, K2, K7, K6, K8, 0, 0, 0}, 3276, 0, 0};

    // Reset state
    repeat (3) @(negedge clk);
    nRST = 1'b1;
    @(negedge clk);
    chk("rst_display", $signed(bus.display_output), 0);
    chk("rst_complete", bus.complete, 0);
    chk("rst_error", bus.error, 0);
    chk("rst_key_ready", bus.key_ready, 1);
    chk("rst_alu_start", bus.alu_start, 0);
    chk("rst_alu_a", $signed(bus.alu_a), 0);
    chk("rst_alu_b", $signed(bus.alu_b), 0);
    chk("rst_alu_op", bus.alu_op, 0);

    // NEG,3,MUL,NEG,4,EQ
    s0 = start_pulses;
    key(KNEG); key(K3); key(KMUL); key(KNEG); key(K4); key(KEQ);
    chk("neg_mul_op", cap_op, 2);
    chk("neg_mul_a", cap_a, -3);
    chk("neg_mul_b", cap_b, -4);
    chk("neg_mul_start_pulses", start_pulses - s0, 1);
    chk("neg_mul_display", $signed(bus.display_output), 12);
    chk("neg_mul_complete", bus.complete, 1);

    // First key from DONE drops complete
    key(K3);
    chk("done_digit_complete", bus.complete, 0);
    chk("done_digit_display", $signed(bus.display_output), 3);
    key(KADD); key(K4); key(KEQ);
    chk("from_done_sum", $signed(bus.display_output), 7);

    // Table
    for (int i = 0; i < 14; i++) begin
      key(KCLR);
      for (int j = 0; j < vt[i].n; j++) key(vt[i].keys[j]);
      chk($sformatf("vec%0d_display", i), $signed(bus.display_output), vt[i].disp);
      chk($sformatf("vec%0d_complete", i), bus.complete, vt[i].cmp);
      chk($sformatf("vec%0d_error", i), bus.error, vt[i].err);
    end

    // ADD then SUB before B digits selects SUB on the bus
    key(KCLR); key(K9); key(KADD); key(KSUB); key(K2); key(KEQ);
    chk("op_replace_alu_op", cap_op, 1);

    // Key held during a slow ALU stalls until DONE
    key(KCLR); key(K2); key(KADD); key(K3);
    alu_lat = 6;
    key(KEQ, 1'b0);
    chk("stall_key_ready", bus.key_ready, 0);
    key(K5);
    chk("stall_waited", last_wait >= 6, 1);
    chk("stall_display", $signed(bus.display_output), 5);
    chk("stall_complete", bus.complete, 0);
    alu_lat = 2;

    // Overflow sets error, CLR clears it
    key(KCLR); key(K3); key(K2); key(K7); key(K6); key(K7);
    chk("max_mag_display", $signed(bus.display_output), 32767);
    key(KADD); key(K1); key(KEQ);
    chk("ovf_error", bus.error, 1);
    chk("ovf_display", $signed(bus.display_output), -32768);
    key(KCLR);
    chk("clr_error", bus.error, 0);
    chk("clr_complete", bus.complete, 0);
    chk("clr_display", $signed(bus.display_output), 0);

    // Reset during WAIT_ALU aborts; stray done is ignored
    key(K1); key(KADD); key(K1);
    alu_lat = 6;
    key(KEQ, 1'b0);
    @(negedge clk);
    nRST = 1'b0;
    #1;
    chk("abort_alu_start", bus.alu_start, 0);
    chk("abort_key_ready", bus.key_ready, 1);
    chk("abort_display", $signed(bus.display_output), 0);
    chk("abort_alu_a", $signed(bus.alu_a), 0);
    @(negedge clk);
    nRST = 1'b1;
    m_clear(); m_st = 0; m_cmp = 0; m_err = 0; m_op = 0;
    repeat (10) @(negedge clk);
    chk("stray_done_complete", bus.complete, 0);
    chk("stray_done_display", $signed(bus.display_output), 0);
    chk("stray_done_error", bus.error, 0);
    alu_lat = 2;

    // Random keys against the model
    for (int i = 0; i < 300; i++) begin
      int k;
      k = int'($urandom_range(0, 15));
      key(k);
      chk($sformatf("rnd%0d_display", i), $signed(bus.display_output), $signed(16'(m_display())));
      chk($sformatf("rnd%0d_complete", i), bus.complete, m_cmp);
      chk($sformatf("rnd%0d_error", i), bus.error, m_err);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
